// File: rtl/trigger_sequencer.sv
// trigger_sequencer: synchronizes vsync/serial/bitplane, edge-detects them and
// issues one stretched send pulse per accepted bitplane edge within a frame.
// Optional build macro TRIGGER_SEQUENCER_DELAY_EN adds parameter DELAY, which
// postpones every send start by DELAY cycles after the accepted bitplane edge.
module trigger_sequencer #(
  parameter int N_BIT_PLANES = 12,
  parameter int DURATION     = 1200,
  parameter int SYNC_STAGES  = 2,
  parameter int FCNT_W       = 16
`ifdef TRIGGER_SEQUENCER_DELAY_EN
  , parameter int DELAY      = 0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              serial,
  input  logic              bitplane,
  output logic              send,
  output logic              busy,
  output logic [7:0]        plane_idx,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DURATION + 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_SER, ARMED, DONE} state_t;

  // Bit order inside each 3-bit slice: [0]=vsync, [1]=serial, [2]=bitplane.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  r_prev;
  logic [2:0]                  r_edge;
  logic [2:0]                  w_in;

  state_t             r_state;
  state_t             w_next;
  logic               w_vs_e, w_ser_e, w_bp_e;
  logic               w_accept, w_drop, w_last;
  logic               w_start, w_slot_busy;
  logic               r_send;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_pidx;
  logic [FCNT_W-1:0]  r_fcnt;
  logic               r_ovr;

  assign w_in    = {bitplane, serial, vsync};
  assign w_vs_e  = r_edge[0];
  assign w_ser_e = r_edge[1];
  assign w_bp_e  = r_edge[2];
  assign w_last  = (({1'b0, r_pidx} + 9'd1) == 9'(N_BIT_PLANES));

  // Synchronizer chain plus registered rising-edge pulse per input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

`ifdef TRIGGER_SEQUENCER_DELAY_EN
  logic        r_pend;
  logic [15:0] r_dcnt;

  // The slot stays occupied from acceptance through the end of the pulse.
  assign w_slot_busy = r_send | r_pend;
  assign w_start     = (DELAY == 0) ? w_accept : (r_pend && (r_dcnt == 16'd0));

  // Delay countdown between an accepted bitplane edge and the send start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_dcnt <= '0;
    end else if (w_accept && (DELAY != 0)) begin
      r_pend <= 1'b1;
      r_dcnt <= 16'(DELAY - 1);
    end else if (r_pend) begin
      if (r_dcnt == 16'd0) r_pend <= 1'b0;
      else                 r_dcnt <= r_dcnt - 16'd1;
    end
  end
`else
  assign w_slot_busy = r_send;
  assign w_start     = w_accept;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_VS;
    else     r_state <= w_next;
  end

  // Next state and accept/drop decisions; vsync overrides everything else.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    if (w_vs_e) begin
      w_next = WAIT_SER;
    end else begin
      case (r_state)
        WAIT_SER: if (w_ser_e) w_next = ARMED;
        ARMED: begin
          if (w_bp_e) begin
            if (w_slot_busy) begin
              w_drop = 1'b1;
            end else begin
              w_accept = 1'b1;
              if (w_last) w_next = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pulse stretcher: runs to completion once started, never retriggers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_send <= 1'b0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_send <= 1'b1;
      r_cnt  <= CNT_W'(DURATION - 1);
    end else if (r_send) begin
      if (r_cnt == '0) r_send <= 1'b0;
      else             r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Frame counter, per-frame plane index and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt <= '0;
      r_pidx <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_vs_e) begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
        r_pidx <= '0;
      end else if (w_accept) begin
        r_pidx <= r_pidx + 8'd1;
      end
      if (w_drop) r_ovr <= 1'b1;
    end
  end

  assign send      = r_send;
  assign busy      = r_send;
  assign plane_idx = r_pidx;
  assign frame_cnt = r_fcnt;
  assign overrun   = r_ovr;

endmodule
